box_feeder: RTL and testbench

Host-side transmitter for the nested-box solver's input port. It buffers (width, height) box records written by a host through a valid/ready port and replays them onto the solver's `width`/`height`/`avail` lines. Pacing guarantees the solver latches every box and has time to sweep its comparison array. It drops records the solver would ignore or miss, and asserts `done` once the solver's result has had time to settle.

---
 rtl/box_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_box_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_feeder.sv
// box_feeder: host-side transmitter for the nested-box solver input port.
// Box records (width, height) are queued from a valid/ready host port and
// replayed one at a time onto the solver's width/height/avail lines. Each
// accepted box is held long enough for the solver to latch it and sweep its
// comparison array. Records the solver would ignore (a zero dimension) or
// miss (identical to the box already presented) are dropped and counted.
// done rises once the last presented box has had time to settle.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   in_valid   - host record valid
//   in_ready   - queue can accept a record (not full)
//   in_width   - host box width
//   in_height  - host box height
//   clear      - synchronous flush: empties the queue and blanks the outputs
//   width      - box width presented to the solver
//   height     - box height presented to the solver
//   avail      - bit 0 = presentation valid, upper bits always 0
//   drop_count - saturating count of dropped records
//   done       - solver result has settled
module box_feeder #(
  parameter int DEPTH  = 16,
  parameter int GAP    = 100,
  parameter int SETTLE = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_width,
  input  logic [31:0] in_height,
  input  logic        clear,
  output logic [31:0] width,
  output logic [31:0] height,
  output logic [31:0] avail,
  output logic [15:0] drop_count,
  output logic        done
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (GAP > SETTLE) ? GAP : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(GAP - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [63:0]   r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_width;
  logic [31:0]   r_height;
  logic          r_avail;
  logic          r_done;
  logic [15:0]   r_drops;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bad;
  logic          w_accept;
  logic          w_drop;
  logic          w_load_settle;
  logic          w_dec;
  logic          w_set_done;
  logic          w_clr_done;
  logic [63:0]   w_head;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pointers carry one extra wrap bit so equal indices can mean full or empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // No bypass: a full queue refuses a push even in a cycle that pops.
  assign w_push  = in_valid && !w_full && !clear;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // A zero dimension is ignored by the solver; a repeat of the presented box
  // would not be latched again, so both are discarded at pop time.
  assign w_bad    = (w_head[63:32] == 32'd0) || (w_head[31:0] == 32'd0) ||
                    (r_avail && (w_head == {r_width, r_height}));
  assign w_accept = w_pop && !w_bad;
  assign w_drop   = w_pop && w_bad;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {in_width, in_height};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_accept) w_next = S_HOLD;
        end else if (r_avail) begin
          w_next = S_SETTLE;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) w_next = w_empty ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        // New work aborts the settle wait; the pop happens from IDLE.
        if (!w_empty)          w_next = S_IDLE;
        else if (r_cnt == '0)  w_next = S_DONE;
      end
      S_DONE: begin
        if (!w_empty) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  always_comb begin
    w_pop         = 1'b0;
    w_load_settle = 1'b0;
    w_dec         = 1'b0;
    w_set_done    = 1'b0;
    w_clr_done    = 1'b0;
    if (!clear) begin
      case (r_state)
        S_IDLE: begin
          w_pop         = !w_empty;
          w_load_settle = w_empty && r_avail;
        end
        S_HOLD: begin
          w_dec         = (r_cnt != '0);
          w_load_settle = (r_cnt == '0) && w_empty;
        end
        S_SETTLE: begin
          w_dec      = w_empty && (r_cnt != '0);
          w_set_done = w_empty && (r_cnt == '0);
        end
        S_DONE: begin
          w_clr_done = !w_empty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_avail  <= 1'b0;
      r_done   <= 1'b0;
      r_drops  <= '0;
    end else if (clear) begin
      // Flush wins over everything; the drop statistics survive.
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_avail  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (w_drop) r_drops <= sat_inc(r_drops);
      if (w_accept) begin
        r_width  <= w_head[63:32];
        r_height <= w_head[31:0];
        r_avail  <= 1'b1;
        r_cnt    <= HOLD_LOAD;
      end else if (w_load_settle) begin
        r_cnt <= SETTLE_LOAD;
      end else if (w_dec) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_set_done)      r_done <= 1'b1;
      else if (w_clr_done) r_done <= 1'b0;
    end
  end

  assign in_ready   = !w_full;
  assign width      = r_width;
  assign height     = r_height;
  assign avail      = {31'd0, r_avail};
  assign drop_count = r_drops;
  assign done       = r_done;

endmodule

// File: tb/tb_box_feeder.sv
// Testbench for box_feeder (DEPTH=4, GAP=4, SETTLE=8). A behavioural model
// built from a record queue and hold/settle deadlines predicts every output.
module tb_box_feeder;
  localparam int DEPTH  = 4;
  localparam int GAP    = 4;
  localparam int SETTLE = 8;
  localparam int P_IDLE = 0, P_HOLD = 1, P_SETTLE = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] in_width = '0;
  logic [31:0] in_height = '0;
  logic        in_ready;
  logic [31:0] width, height, avail;
  logic [15:0] drop_count;
  logic        done;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [63:0] m_q[$];
  logic [31:0] m_w, m_h;
  logic        m_av, m_done;
  logic [15:0] m_drops;
  int          m_ph, m_hold_end, m_settle_end, m_n;
  bit          m_pushed;

  box_feeder #(.DEPTH(DEPTH), .GAP(GAP), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_width(in_width), .in_height(in_height), .clear(clear),
    .width(width), .height(height), .avail(avail),
    .drop_count(drop_count), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need normal finish");
    $fatal(1);
  end

  function automatic void model_reset();
    m_q.delete();
    m_w = '0; m_h = '0; m_av = 1'b0; m_done = 1'b0; m_drops = '0;
    m_ph = P_IDLE; m_hold_end = 0; m_settle_end = 0;
  endfunction

  // One rising edge: decisions use the queue as it stood before the edge.
  function automatic void model_edge(input logic v, input logic [31:0] iw,
                                     input logic [31:0] ih, input logic c);
    int pre;
    bit ne;
    logic [63:0] r;
    pre = m_q.size();
    ne = (pre != 0);
    m_pushed = v && (pre < DEPTH) && !c;
    if (c) begin
      m_q.delete();
      m_w = '0; m_h = '0; m_av = 1'b0; m_done = 1'b0; m_ph = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE: begin
          if (ne) begin
            r = m_q.pop_front();
            if (r[63:32] == 0 || r[31:0] == 0 || (m_av && r == {m_w, m_h})) begin
              if (m_drops != 16'hFFFF) m_drops++;
            end else begin
              m_w = r[63:32]; m_h = r[31:0]; m_av = 1'b1;
              m_hold_end = m_n + GAP; m_ph = P_HOLD;
            end
          end else if (m_av) begin
            m_settle_end = m_n + SETTLE; m_ph = P_SETTLE;
          end
        end
        P_HOLD: begin
          if (m_n == m_hold_end) begin
            if (ne) m_ph = P_IDLE;
            else begin m_settle_end = m_n + SETTLE; m_ph = P_SETTLE; end
          end
        end
        P_SETTLE: begin
          if (ne) m_ph = P_IDLE;
          else if (m_n == m_settle_end) begin m_ph = P_DONE; m_done = 1'b1; end
        end
        default: begin
          if (ne) begin m_ph = P_IDLE; m_done = 1'b0; end
        end
      endcase
    end
    if (m_pushed) m_q.push_back({iw, ih});
    m_n++;
  endfunction

  function automatic logic [113:0] exp_vec();
    return {m_w, m_h, {31'd0, m_av}, m_drops, m_done, (m_q.size() < DEPTH)};
  endfunction

  function automatic logic [113:0] obs_vec();
    return {width, height, avail, drop_count, done, in_ready};
  endfunction

  function automatic string fmt(input logic [113:0] v);
    return $sformatf("w=%0d h=%0d avail=%0h drops=%0d done=%b rdy=%b",
                     v[113:82], v[81:50], v[49:18], v[17:2], v[1], v[0]);
  endfunction

  task automatic tick(input logic v, input logic [31:0] iw,
                      input logic [31:0] ih, input logic c);
    in_valid = v; in_width = iw; in_height = ih; clear = c;
    @(posedge clk);
    model_edge(v, iw, ih, c);
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset: got %s need %s", fmt(obs_vec()), fmt(exp_vec()));
    end
    checks++;
    if (obs_vec() !== {32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_values: got %s need all zero, rdy=1", fmt(obs_vec()));
    end
    rst = 1'b1;
    m_n = 0;
  endtask

  task automatic test_single();
    int dr = -1;
    tick(1'b1, 32'd5, 32'd7, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL single t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (i == 1) begin
        checks++;
        if ({width, height, avail} !== {32'd5, 32'd7, 32'd1}) begin
          failures++; $display("FAIL single_latency: got %s need w=5 h=7 avail=1", fmt(obs_vec()));
        end
      end
      if (done === 1'b1 && dr < 0) dr = i;
    end
    checks++;
    if (dr != 1 + GAP + SETTLE) begin
      failures++; $display("FAIL single_done_edge: got %0d need %0d", dr, 1 + GAP + SETTLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] st [3] = '{{32'd3, 32'd3}, {32'd3, 32'd3}, {32'd4, 32'd6}};
    logic [63:0] seq[$];
    logic [63:0] last;
    logic [15:0] d0;
    d0 = m_drops;
    last = {width, height};
    for (int i = 0; i < 33; i++) begin
      if (i < 3) tick(1'b1, st[i][63:32], st[i][31:0], 1'b0);
      else       tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL back_to_back t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      if ({width, height} !== last) begin
        last = {width, height};
        seq.push_back(last);
      end
    end
    checks++;
    if (seq.size() != 2 || seq[0] !== {32'd3, 32'd3} || seq[1] !== {32'd4, 32'd6}) begin
      failures++; $display("FAIL back_to_back_order: got %0d changes need (3,3) then (4,6)", seq.size());
    end
    checks++;
    if (drop_count !== d0 + 16'd1) begin
      failures++; $display("FAIL back_to_back_drops: got %0d need %0d", drop_count, d0 + 16'd1);
    end
  endtask

  task automatic test_drops_zero();
    logic [15:0] d0;
    tick(1'b0, 32'd0, 32'd0, 1'b1);
    d0 = m_drops;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      tick(1'b1, 32'd0, 32'd9, 1'b0);
      else if (i == 1) tick(1'b1, 32'd8, 32'd0, 1'b0);
      else             tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL drops_zero t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
    checks++;
    if ({width, height, avail, drop_count} !== {32'd0, 32'd0, 32'd0, d0 + 16'd2}) begin
      failures++; $display("FAIL drops_zero_final: got %s need outputs 0 drops=%0d", fmt(obs_vec()), d0 + 16'd2);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pend[$];
    logic [63:0] expq[$];
    logic [63:0] seq[$];
    logic [63:0] last;
    bit saw_full = 0;
    bit fin = 0;
    bit ok;
    tick(1'b0, 32'd0, 32'd0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      pend.push_back({32'(10 + k), 32'(20 + k)});
      expq.push_back({32'(10 + k), 32'(20 + k)});
    end
    last = {width, height};
    for (int i = 0; i < 200 && !fin; i++) begin
      if (pend.size() > 0) tick(1'b1, pend[0][63:32], pend[0][31:0], 1'b0);
      else                 tick(1'b0, 32'd0, 32'd0, 1'b0);
      if (m_pushed) void'(pend.pop_front());
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL backpressure t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (in_ready === 1'b0) saw_full = 1;
      if (avail[0] === 1'b1 && {width, height} !== last) begin
        last = {width, height};
        seq.push_back(last);
      end
      if (pend.size() == 0 && m_done) fin = 1;
    end
    checks++;
    if (!fin) begin
      failures++; $display("FAIL backpressure_timeout: got no completion need done within 200 cycles");
    end
    ok = (seq.size() == expq.size());
    for (int k = 0; k < seq.size() && ok; k++) if (seq[k] !== expq[k]) ok = 0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL backpressure_order: got %0d boxes need 7 in push order", seq.size());
    end
    checks++;
    if (!saw_full) begin
      failures++; $display("FAIL backpressure_ready: got in_ready never low need a full queue");
    end
  endtask

  task automatic test_done_repush();
    int fall = -1, rise = -1;
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL repush_start: got done=%b need 1", done);
    end
    tick(1'b1, 32'd9, 32'd9, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL repush t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (done === 1'b0 && fall < 0) fall = i;
      if (done === 1'b1 && fall > 0 && rise < 0) rise = i;
    end
    checks++;
    if (fall != 1 || rise != 2 + GAP + SETTLE || {width, height} !== {32'd9, 32'd9}) begin
      failures++; $display("FAIL repush_timing: got fall=%0d rise=%0d w=%0d h=%0d need fall=1 rise=%0d (9,9)",
                           fall, rise, width, height, 2 + GAP + SETTLE);
    end
  endtask

  task automatic test_clear_push();
    logic [15:0] d0;
    tick(1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 32'd2, 32'd5, 1'b0);
    tick(1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b0, 32'd0, 32'd0, 1'b0);
    d0 = m_drops;
    tick(1'b1, 32'd6, 32'd6, 1'b1);
    checks++;
    if (obs_vec() !== {32'd0, 32'd0, 32'd0, d0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL clear_push: got %s need outputs 0 drops=%0d rdy=1", fmt(obs_vec()), d0);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL clear_after t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 32'd7, 32'd1, 1'b0);
    for (int i = 0; i < GAP + 3; i++) begin
      tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL async_pre t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== {32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL async_reset: got %s need all zero, rdy=1", fmt(obs_vec()));
    end
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL async_post t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_random();
    logic v, c;
    logic [31:0] w, h;
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) == 0);
      w = 32'($urandom_range(0, 3));
      h = 32'($urandom_range(0, 3));
      c = ($urandom_range(0, 63) == 0);
      tick(v, w, h, c);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random t%0d: got %s need %s", i, fmt(obs_vec()), fmt(exp_vec()));
      end
    end
  endtask

  initial begin
    model_reset();
    m_n = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drops_zero();
    test_backpressure();
    test_done_repush();
    test_clear_push();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
